// File: rtl/tc_sram_rr_arb.sv
// Round-robin arbiter that shares one SRAM port among NumReq requesters and
// routes each read response back to the requester that issued it.
module tc_sram_rr_arb #(
   parameter int unsigned NumReq    = 4,
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned IdxWidth  = $clog2(NumReq)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NumReq-1:0]                   req_i,
   input  logic [NumReq-1:0]                   we_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
   input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
   input  logic [NumReq-1:0][BeWidth-1:0]      be_i,
   output logic [NumReq-1:0]                   gnt_o,
   output logic [NumReq-1:0]                   rvalid_o,
   output logic [NumReq-1:0][DataWidth-1:0]    rdata_o,
   output logic                                sram_req_o,
   output logic                                sram_we_o,
   output logic [AddrWidth-1:0]                sram_addr_o,
   output logic [DataWidth-1:0]                sram_wdata_o,
   output logic [BeWidth-1:0]                  sram_be_o,
   input  logic [DataWidth-1:0]                sram_rdata_i
);

   logic [IdxWidth-1:0]               r_ptr;
   logic [NumReq-1:0]                 w_gnt;
   logic                              w_any;
   logic [IdxWidth-1:0]               w_idx;
   logic [Latency-1:0]                r_vld;
   logic [Latency-1:0][IdxWidth-1:0]  r_idx;

   // Search upward from r_ptr, wrapping at NumReq; first requester wins.
   always_comb begin
      int unsigned w_k;
      w_gnt = '0;
      w_any = 1'b0;
      w_idx = '0;
      w_k   = 0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         w_k = int'(r_ptr) + i;
         if (w_k >= NumReq) begin
            w_k = w_k - NumReq;
         end
         if (!w_any && req_i[w_k]) begin
            w_any = 1'b1;
            w_idx = IdxWidth'(w_k);
         end
      end
      w_gnt[w_idx] = w_any;
   end

   assign gnt_o        = w_gnt;
   assign sram_req_o   = w_any;
   assign sram_we_o    = w_any & we_i[w_idx];
   assign sram_addr_o  = w_any ? addr_i[w_idx]  : '0;
   assign sram_wdata_o = w_any ? wdata_i[w_idx] : '0;
   assign sram_be_o    = w_any ? be_i[w_idx]    : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (w_any) begin
         r_ptr <= (w_idx == IdxWidth'(NumReq - 1)) ? '0 : w_idx + 1'b1;
      end
   end

   // Read-tracking pipe: only the valid bits need reset to drop reads in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= w_any & ~we_i[w_idx];
         for (int unsigned s = 1; s < Latency; s++) begin
            r_vld[s] <= r_vld[s-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      r_idx[0] <= w_idx;
      for (int unsigned s = 1; s < Latency; s++) begin
         r_idx[s] <= r_idx[s-1];
      end
   end

   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (r_vld[Latency-1] && (r_idx[Latency-1] == IdxWidth'(k))) begin
            rvalid_o[k] = 1'b1;
            rdata_o[k]  = sram_rdata_i;
         end
      end
   end

endmodule
